// File: rtl/ps2_key_event_fifo.sv
// PS/2 set-2 scancode decoder with modifier tracking and a first-word-fall-through event FIFO.
// Events are {break, extended, code}; the FIFO is popped one entry per cycle by the CPU.
module ps2_key_event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    code_in,
    input  logic          code_valid,
    input  logic          rd_en,
    input  logic          clr,
    output logic [9:0]    ev_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          mod_shift,
    output logic          mod_ctrl,
    output logic          mod_alt
);

    typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StSkip} state_e;

    localparam logic [AW:0] DepthC = (AW+1)'(DEPTH);

    state_e         state_q, state_d;
    logic [2:0]     skip_q, skip_d;
    logic           shl_q, shl_d, shr_q, shr_d;
    logic           ctl_q, ctl_d, ctr_q, ctr_d;
    logic           all_q, all_d, alr_q, alr_d;
    logic [9:0]     mem_q [DEPTH];
    logic [9:0]     mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d, remain;
    logic           empty_q, empty_d, full_q, full_d, ovf_q, ovf_d;
    logic [9:0]     ev_data_q, ev_data_d;

    logic           ev_push, ev_brk, ev_ext, is_noise, is_fake, do_push, do_pop;
    logic [9:0]     ev_word;

    always_comb begin
        is_noise = 1'b0;
        case (code_in)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_noise = 1'b1;
            default: is_noise = 1'b0;
        endcase
        is_fake = (code_in == 8'h12) || (code_in == 8'h59);
    end

    // Decoder: prefix bytes only move the FSM; the final byte of a sequence raises ev_push.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        ev_push = 1'b0;
        ev_brk  = 1'b0;
        ev_ext  = 1'b0;
        if (code_valid) begin
            case (state_q)
                StIdle: begin
                    if (code_in == 8'hE0) begin
                        state_d = StExt;
                    end else if (code_in == 8'hF0) begin
                        state_d = StBrk;
                    end else if (code_in == 8'hE1) begin
                        state_d = StSkip;
                        skip_d  = 3'd7;
                    end else if (!is_noise) begin
                        ev_push = 1'b1;
                    end
                end
                StExt: begin
                    if (code_in == 8'hF0) begin
                        state_d = StExtBrk;
                    end else begin
                        state_d = StIdle;
                        ev_push = !is_fake;
                        ev_ext  = 1'b1;
                    end
                end
                StBrk: begin
                    state_d = StIdle;
                    ev_push = 1'b1;
                    ev_brk  = 1'b1;
                end
                StExtBrk: begin
                    state_d = StIdle;
                    ev_push = !is_fake;
                    ev_brk  = 1'b1;
                    ev_ext  = 1'b1;
                end
                StSkip: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
        if (clr) begin
            state_d = StIdle;
            skip_d  = 3'd0;
            ev_push = 1'b0;
        end
    end

    // Modifiers follow decoded events even when the FIFO drops them.
    always_comb begin
        shl_d = shl_q;
        shr_d = shr_q;
        ctl_d = ctl_q;
        ctr_d = ctr_q;
        all_d = all_q;
        alr_d = alr_q;
        if (ev_push) begin
            if (!ev_ext) begin
                if (code_in == 8'h12) shl_d = !ev_brk;
                if (code_in == 8'h59) shr_d = !ev_brk;
                if (code_in == 8'h14) ctl_d = !ev_brk;
                if (code_in == 8'h11) all_d = !ev_brk;
            end else begin
                if (code_in == 8'h14) ctr_d = !ev_brk;
                if (code_in == 8'h11) alr_d = !ev_brk;
            end
        end
        if (clr) begin
            {shl_d, shr_d, ctl_d, ctr_d, all_d, alr_d} = 6'b0;
        end
    end

    assign ev_word = {ev_brk, ev_ext, code_in};

    always_comb begin
        do_pop    = rd_en && (count_q != '0) && !clr;
        do_push   = ev_push && (!full_q || do_pop);
        ovf_d     = ovf_q || (ev_push && full_q && !do_pop);
        remain    = count_q - (AW+1)'(do_pop);
        count_d   = remain + (AW+1)'(do_push);
        rd_ptr_d  = rd_ptr_q + AW'(do_pop);
        wr_ptr_d  = wr_ptr_q + AW'(do_push);
        mem_d     = mem_q;
        if (do_push) mem_d[wr_ptr_q] = ev_word;
        ev_data_d = ev_data_q;
        // Head after this edge: the new word if it lands in an otherwise empty FIFO.
        if (count_d != '0) ev_data_d = (remain == '0) ? ev_word : mem_q[rd_ptr_d];
        if (clr) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            ovf_d    = 1'b0;
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == DepthC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            skip_q    <= 3'd0;
            {shl_q, shr_q, ctl_q, ctr_q, all_q, alr_q} <= 6'b0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            ev_data_q <= '0;
        end else begin
            state_q   <= state_d;
            skip_q    <= skip_d;
            {shl_q, shr_q, ctl_q, ctr_q, all_q, alr_q} <=
                {shl_d, shr_d, ctl_d, ctr_d, all_d, alr_d};
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            ev_data_q <= ev_data_d;
        end
    end

    assign ev_data   = ev_data_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign mod_shift = shl_q | shr_q;
    assign mod_ctrl  = ctl_q | ctr_q;
    assign mod_alt   = all_q | alr_q;

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Directed bench for ps2_key_event_fifo: decoder sequences, modifiers, FIFO limits, clr and reset.
module tb_ps2_key_event_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] code_in = 8'h00;
    logic       code_valid = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr = 1'b0;
    logic [9:0] ev_data;
    logic       empty, full, overflow, mod_shift, mod_ctrl, mod_alt;
    logic [3:0] count;

    int vecs = 0;
    int errs = 0;

    ps2_key_event_fifo #(.DEPTH(8), .AW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_in    (code_in),
        .code_valid (code_valid),
        .rd_en      (rd_en),
        .clr        (clr),
        .ev_data    (ev_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .mod_shift  (mod_shift),
        .mod_ctrl   (mod_ctrl),
        .mod_alt    (mod_alt)
    );

    always #5 clk = ~clk;

    // One byte per rising edge; consecutive calls give back-to-back strobes.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        code_in = b;
        code_valid = 1'b1;
        @(posedge clk);
        #1 code_valid = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty got %b want 1", empty); end
        vecs++; if (full !== 1'b0) begin errs++; $display("FAIL reset_full got %b want 0", full); end
        vecs++; if (count !== 4'd0) begin errs++; $display("FAIL reset_count got %0d want 0", count); end
        vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL reset_ovf got %b want 0", overflow); end
        vecs++; if ({mod_shift, mod_ctrl, mod_alt} !== 3'b000) begin errs++;
            $display("FAIL reset_mods got %b want 000", {mod_shift, mod_ctrl, mod_alt}); end
        vecs++; if (ev_data !== 10'h000) begin errs++; $display("FAIL reset_ev got %h want 000", ev_data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_make_break();
        send(8'h1C);
        vecs++; if (ev_data !== 10'h01C) begin errs++; $display("FAIL make_head got %h want 01C", ev_data); end
        vecs++; if (empty !== 1'b0) begin errs++; $display("FAIL make_empty got %b want 0", empty); end
        send(8'hF0);
        vecs++; if (count !== 4'd1) begin errs++; $display("FAIL prefix_count got %0d want 1", count); end
        send(8'h1C);
        vecs++; if (count !== 4'd2) begin errs++; $display("FAIL mb_count got %0d want 2", count); end
        vecs++; if ({mod_shift, mod_ctrl, mod_alt} !== 3'b000) begin errs++;
            $display("FAIL mb_mods got %b want 000", {mod_shift, mod_ctrl, mod_alt}); end
        pop();
        vecs++; if (ev_data !== 10'h21C) begin errs++; $display("FAIL brk_head got %h want 21C", ev_data); end
        pop();
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL mb_drain got %b want 1", empty); end
    endtask

    task automatic test_extended();
        logic [9:0] exp [3];
        exp = '{10'h175, 10'h375, 10'h01C};
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'h1C);
        vecs++; if (count !== 4'd3) begin errs++; $display("FAIL ext_count got %0d want 3", count); end
        for (int i = 0; i < 3; i++) begin
            vecs++; if (ev_data !== exp[i]) begin errs++;
                $display("FAIL ext_ev[%0d] got %h want %h", i, ev_data, exp[i]); end
            pop();
        end
    endtask

    task automatic test_modifiers();
        send(8'h12);
        vecs++; if (mod_shift !== 1'b1) begin errs++; $display("FAIL lshift got %b want 1", mod_shift); end
        send(8'h59); send(8'hF0); send(8'h12);
        vecs++; if (mod_shift !== 1'b1) begin errs++; $display("FAIL rshift_hold got %b want 1", mod_shift); end
        send(8'hF0); send(8'h59);
        vecs++; if (mod_shift !== 1'b0) begin errs++; $display("FAIL shift_rel got %b want 0", mod_shift); end
        send(8'hE0); send(8'h14);
        vecs++; if (mod_ctrl !== 1'b1) begin errs++; $display("FAIL rctrl got %b want 1", mod_ctrl); end
        vecs++; if (count !== 4'd5) begin errs++; $display("FAIL mod_count got %0d want 5", count); end
        vecs++; if (ev_data !== 10'h012) begin errs++; $display("FAIL mod_head got %h want 012", ev_data); end
        send(8'h11);
        vecs++; if (mod_alt !== 1'b1) begin errs++; $display("FAIL lalt got %b want 1", mod_alt); end
        send(8'hE0); send(8'hF0); send(8'h14);
        vecs++; if (mod_ctrl !== 1'b0) begin errs++; $display("FAIL rctrl_rel got %b want 0", mod_ctrl); end
        do_clr();
        vecs++; if (mod_alt !== 1'b0) begin errs++; $display("FAIL clr_alt got %b want 0", mod_alt); end
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL mod_clr got %b want 1", empty); end
    endtask

    task automatic test_skip();
        logic [7:0] seq [10];
        seq = '{8'hAA, 8'hFA, 8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        foreach (seq[i]) send(seq[i]);
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL skip_empty got %b want 1", empty); end
        vecs++; if (mod_ctrl !== 1'b0) begin errs++; $display("FAIL skip_mods got %b want 0", mod_ctrl); end
        send(8'hE0); send(8'h12);
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL fake_shift got %b want 1", empty); end
        send(8'h1C);
        vecs++; if (ev_data !== 10'h01C) begin errs++; $display("FAIL skip_next got %h want 01C", ev_data); end
        vecs++; if (count !== 4'd1) begin errs++; $display("FAIL skip_count got %0d want 1", count); end
        pop();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 8; i++) send(8'(i));
        vecs++; if (full !== 1'b1) begin errs++; $display("FAIL full8 got %b want 1", full); end
        vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL ovf_early got %b want 0", overflow); end
        send(8'h09);
        vecs++; if (count !== 4'd8) begin errs++; $display("FAIL ovf_count got %0d want 8", count); end
        vecs++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_set got %b want 1", overflow); end
        vecs++; if (ev_data !== 10'h001) begin errs++; $display("FAIL ovf_head got %h want 001", ev_data); end
        @(negedge clk);
        code_in = 8'h0A; code_valid = 1'b1; rd_en = 1'b1;
        @(posedge clk);
        #1 code_valid = 1'b0; rd_en = 1'b0;
        vecs++; if (count !== 4'd8) begin errs++; $display("FAIL pushpop_count got %0d want 8", count); end
        for (int i = 0; i < 8; i++) begin
            logic [9:0] want;
            want = (i == 7) ? 10'h00A : 10'(i + 2);
            vecs++; if (ev_data !== want) begin errs++;
                $display("FAIL order[%0d] got %h want %h", i, ev_data, want); end
            pop();
        end
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL drain_empty got %b want 1", empty); end
        pop();
        vecs++; if (count !== 4'd0) begin errs++; $display("FAIL pop_empty got %0d want 0", count); end
        vecs++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        @(negedge clk);
        code_in = 8'h1C; code_valid = 1'b1; rd_en = 1'b1;
        @(posedge clk);
        #1 code_valid = 1'b0; rd_en = 1'b0;
        vecs++; if (count !== 4'd1) begin errs++; $display("FAIL empty_pushpop got %0d want 1", count); end
        vecs++; if (ev_data !== 10'h01C) begin errs++; $display("FAIL empty_pp_head got %h want 01C", ev_data); end
    endtask

    task automatic test_clr();
        for (int i = 1; i <= 9; i++) send(8'(i + 16));
        send(8'h12);
        vecs++; if (mod_shift !== 1'b1) begin errs++; $display("FAIL full_mod got %b want 1", mod_shift); end
        send(8'hE0);
        @(negedge clk);
        clr = 1'b1; code_in = 8'h75; code_valid = 1'b1; rd_en = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0; code_valid = 1'b0; rd_en = 1'b0;
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL clr_empty got %b want 1", empty); end
        vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL clr_ovf got %b want 0", overflow); end
        vecs++; if (mod_shift !== 1'b0) begin errs++; $display("FAIL clr_mod got %b want 0", mod_shift); end
        send(8'h75);
        vecs++; if (ev_data !== 10'h075) begin errs++; $display("FAIL clr_fsm got %h want 075", ev_data); end
    endtask

    task automatic test_async_reset();
        send(8'h12);
        send(8'hE0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vecs++; if (count !== 4'd0) begin errs++; $display("FAIL arst_count got %0d want 0", count); end
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL arst_empty got %b want 1", empty); end
        vecs++; if (mod_shift !== 1'b0) begin errs++; $display("FAIL arst_mod got %b want 0", mod_shift); end
        vecs++; if (ev_data !== 10'h000) begin errs++; $display("FAIL arst_ev got %h want 000", ev_data); end
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h75);
        vecs++; if (ev_data !== 10'h075) begin errs++; $display("FAIL arst_fsm got %h want 075", ev_data); end
        vecs++; if (count !== 4'd1) begin errs++; $display("FAIL arst_cnt1 got %0d want 1", count); end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_modifiers();
        test_skip();
        test_overflow();
        test_clr();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
